flash_burst_reader: RTL and testbench

FLASH_BURST_READER -- requirements
Module: flash_burst_reader

---
 rtl/flash_burst_reader.sv | 204 ++++++++++++++++++++
 tb/tb_flash_burst_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_burst_reader.sv
// SPI (mode 3) flash burst reader: issues READ/FAST_READ with a start
// address and streams back req_len words through a valid/ready port.
module flash_burst_reader #(
    parameter int ADDR_W       = 24,
    parameter int WORD_W       = 32,
    parameter int MAX_WORDS    = 16,
    parameter int DUMMY_CYCLES = 8,
    parameter int CLK_DIV      = 1,
    parameter int CSH_CYCLES   = 2,
    parameter int LEN_W        = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_start,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              req_fast,
    input  logic              abort,
    output logic              busy,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              rd_done,
    output logic              rd_err,
    output logic              spi_clk,
    output logic              spi_sel,
    output logic              spi0,
    input  logic              spi1
);

    localparam int MAXB0 = (ADDR_W > WORD_W) ? ADDR_W : WORD_W;
    localparam int MAXB1 = (MAXB0 > DUMMY_CYCLES) ? MAXB0 : DUMMY_CYCLES;
    localparam int MAXB  = (MAXB1 > 8) ? MAXB1 : 8;
    localparam int BIT_W = $clog2(MAXB);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CSH_W = (CSH_CYCLES > 1) ? $clog2(CSH_CYCLES) : 1;
    localparam int TX_W  = 8 + ADDR_W;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, DATA, HOLD, CSH
    } state_t;

    state_t             state, state_nx;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [LEN_W-1:0]   word_cnt;
    logic [LEN_W-1:0]   len_q;
    logic [CSH_W-1:0]   csh_cnt;
    logic [TX_W-1:0]    tx_sr;
    logic [WORD_W-2:0]  rx_sr;
    logic               fast_q;
    logic               err_q;

    logic active, tick, last_bit, burst_fin, hold_now;
    logic rise_ev, fall_ev, csh_done, len_ok, sel_up;
    int   phase_last;

    assign busy     = (state != IDLE);
    assign tick     = (int'(div_cnt) == CLK_DIV - 1);
    assign csh_done = (int'(csh_cnt) >= CSH_CYCLES - 1);
    assign len_ok   = (req_len != '0) && (int'(req_len) <= MAX_WORDS);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // SCK event decode and next-state selection
    always_comb begin
        state_nx   = state;
        active     = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
        phase_last = WORD_W - 1;
        case (state)
            CMD:     phase_last = 7;
            ADDR:    phase_last = ADDR_W - 1;
            DUMMY:   phase_last = DUMMY_CYCLES - 1;
            default: phase_last = WORD_W - 1;
        endcase
        last_bit  = (int'(bit_cnt) == phase_last);
        burst_fin = (state == DATA) && (word_cnt == len_q);
        // a new word may only start once the previous one is taken (or being taken now)
        hold_now  = (state == DATA) && (bit_cnt == '0) && (word_cnt != '0) && !burst_fin
                    && rd_valid && !rd_ready;
        rise_ev   = active && tick && !spi_clk;
        fall_ev   = active && tick && spi_clk && !burst_fin && !hold_now;
        sel_up    = (state == DATA) && tick && spi_clk && burst_fin;
        case (state)
            IDLE:    if (req_start && len_ok) state_nx = CMD;
            CMD:     if (rise_ev && last_bit) state_nx = ADDR;
            ADDR:    if (rise_ev && last_bit) state_nx = fast_q ? DUMMY : DATA;
            DUMMY:   if (rise_ev && last_bit) state_nx = DATA;
            DATA: begin
                if (sel_up)                         state_nx = CSH;
                else if (tick && spi_clk && hold_now) state_nx = HOLD;
            end
            HOLD:    if (rd_ready) state_nx = DATA;
            CSH:     if (csh_done && (!rd_valid || rd_ready)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (state != IDLE && abort) state_nx = CSH;
    end

    // Datapath: SCK divider, shifters, counters, output word buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            len_q    <= '0;
            csh_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            fast_q   <= 1'b0;
            err_q    <= 1'b0;
            spi_clk  <= 1'b1;
            spi_sel  <= 1'b1;
            spi0     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_done  <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            rd_err  <= 1'b0;
            if (state == IDLE) begin
                div_cnt  <= '0;
                bit_cnt  <= '0;
                word_cnt <= '0;
                csh_cnt  <= '0;
                if (req_start) begin
                    if (len_ok) begin
                        spi_sel <= 1'b0;
                        tx_sr   <= {(req_fast ? 8'h0B : 8'h03), req_addr};
                        len_q   <= req_len;
                        fast_q  <= req_fast;
                        err_q   <= 1'b0;
                    end else begin
                        rd_done <= 1'b1;
                        rd_err  <= 1'b1;
                    end
                end
            end else if (abort) begin
                spi_clk  <= 1'b1;
                spi_sel  <= 1'b1;
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
                err_q    <= 1'b1;
                div_cnt  <= '0;
                if (state != CSH) csh_cnt <= '0;
            end else begin
                if (active) div_cnt <= tick ? '0 : div_cnt + 1'b1;
                else        div_cnt <= '0;

                if (fall_ev) begin
                    spi_clk <= 1'b0;
                    if (state == CMD || state == ADDR) begin
                        spi0  <= tx_sr[TX_W-1];
                        tx_sr <= tx_sr << 1;
                    end else begin
                        spi0 <= 1'b0;
                    end
                end

                if (rise_ev) begin
                    spi_clk <= 1'b1;
                    bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                    if (state == DATA) begin
                        rx_sr <= (WORD_W-1)'({rx_sr, spi1});
                        if (last_bit) word_cnt <= word_cnt + 1'b1;
                    end
                end

                if (sel_up) begin
                    spi_sel <= 1'b1;
                    csh_cnt <= '0;
                end

                if (state == CSH) begin
                    if (csh_done && (!rd_valid || rd_ready)) begin
                        rd_done <= 1'b1;
                        rd_err  <= err_q;
                        spi0    <= 1'b0;
                    end else if (!csh_done) begin
                        csh_cnt <= csh_cnt + 1'b1;
                    end
                end

                // completed word wins over a same-cycle handshake: no bubble
                if (rise_ev && state == DATA && last_bit) begin
                    rd_data  <= {rx_sr, spi1};
                    rd_valid <= 1'b1;
                    rd_last  <= (word_cnt + 1'b1 == len_q);
                end else if (rd_valid && rd_ready) begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_flash_burst_reader.sv
// Directed bench for flash_burst_reader with a behavioural SPI flash model.
module tb_flash_burst_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_start = 1'b0;
    logic [23:0] req_addr = '0;
    logic [4:0]  req_len = '0;
    logic        req_fast = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic        rd_last;
    logic        rd_done;
    logic        rd_err;
    logic        spi_clk;
    logic        spi_sel;
    logic        spi0;
    logic        spi1 = 1'b0;

    always #5 clk = ~clk;

    flash_burst_reader #(
        .ADDR_W(24), .WORD_W(32), .MAX_WORDS(16),
        .DUMMY_CYCLES(8), .CLK_DIV(2), .CSH_CYCLES(2)
    ) u_dut (
        .clk(clk), .rst(rst), .req_start(req_start), .req_addr(req_addr),
        .req_len(req_len), .req_fast(req_fast), .abort(abort), .busy(busy),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_last(rd_last), .rd_done(rd_done), .rd_err(rd_err),
        .spi_clk(spi_clk), .spi_sel(spi_sel), .spi0(spi0), .spi1(spi1)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // flash model: header bits on MOSI, data words on MISO after hdr rises
    logic [31:0] dwords [16];
    int          hdr = 32;
    int          nrise = 0;
    int          late_ones = 0;
    logic [31:0] cmd_sr = '0;

    always @(negedge spi_sel) begin
        nrise = 0;
        late_ones = 0;
        cmd_sr = '0;
    end

    always @(posedge spi_clk) if (spi_sel === 1'b0) begin
        if (nrise < 32) cmd_sr = {cmd_sr[30:0], spi0};
        else if (spi0 === 1'b1) late_ones++;
        nrise++;
    end

    always @(negedge spi_clk) if (spi_sel === 1'b0) begin
        if (nrise >= hdr && (nrise - hdr) / 32 < 16) begin
            automatic int bi = nrise - hdr;
            automatic logic [31:0] w = dwords[bi / 32];
            spi1 = w[31 - (bi % 32)];
        end else begin
            spi1 = 1'b0;
        end
    end

    // output collector and SCK timing monitor
    logic [31:0] got_w [$];
    logic        got_l [$];
    int   n_done = 0;
    logic last_err = 1'b0;
    int   sel_low_cnt = 0;
    int   lvl_len = 0, lvl_bad = 0, hi_run = 0, max_hi = 0;
    logic lvl_en = 1'b0;
    logic prev_clk = 1'b1;

    always @(negedge clk) begin
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            got_w.push_back(rd_data);
            got_l.push_back(rd_last);
        end
        if (rd_done === 1'b1) begin
            n_done++;
            last_err = rd_err;
        end
        if (spi_sel !== 1'b0) begin
            lvl_len = 0;
            hi_run = 0;
        end else begin
            sel_low_cnt++;
            if (spi_clk !== prev_clk && lvl_len != 0) begin
                if (lvl_en && lvl_len != 2) lvl_bad++;
                lvl_len = 1;
            end else begin
                lvl_len++;
            end
            hi_run = (spi_clk === 1'b1) ? hi_run + 1 : 0;
            if (hi_run > max_hi) max_hi = hi_run;
        end
        prev_clk = spi_clk;
    end

    function automatic logic [31:0] gw(input int i);
        return (i < got_w.size()) ? got_w[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [15:0] lasts();
        logic [15:0] v = '0;
        for (int i = 0; i < got_l.size() && i < 16; i++) v[i] = got_l[i];
        return v;
    endfunction

    task automatic start(input logic [23:0] a, input logic [4:0] l, input logic f);
        @(posedge clk); #1;
        req_addr = a; req_len = l; req_fast = f; req_start = 1'b1;
        hdr = f ? 40 : 32;
        got_w.delete();
        got_l.delete();
        @(posedge clk); #1;
        req_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0 = n_done;
        int k = 0;
        while (n_done == n0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, " done seen"}, 64'(n_done != n0), 64'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nd, sl;

        // reset state
        cycles(3);
        @(negedge clk);
        chk("rst sel", spi_sel, 1);
        chk("rst sck", spi_clk, 1);
        chk("rst mosi", spi0, 0);
        chk("rst busy", busy, 0);
        chk("rst valid", rd_valid, 0);
        chk("rst done", {rd_done, rd_err, rd_last}, 0);
        chk("rst data", rd_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // normal read, one word
        dwords[0] = 32'hDEADBEEF;
        start(24'h123456, 5'd1, 1'b0);
        wait_done("t1", 1000);
        chk("t1 mosi hdr", cmd_sr, 32'h03123456);
        chk("t1 sck count", nrise, 64);
        chk("t1 mosi idle", late_ones, 0);
        chk("t1 nwords", got_w.size(), 1);
        chk("t1 word", gw(0), 32'hDEADBEEF);
        chk("t1 last", lasts(), 16'h0001);
        chk("t1 err", last_err, 0);
        chk("t1 busy", busy, 0);

        // fast read, four words, SCK level timing, req_start ignored mid-burst
        dwords[0] = 32'h01234567; dwords[1] = 32'h89ABCDEF;
        dwords[2] = 32'hCAFEF00D; dwords[3] = 32'h5A5AA5A5;
        lvl_en = 1'b1; lvl_bad = 0;
        nd = n_done;
        start(24'hABCDEF, 5'd4, 1'b1);
        cycles(30);
        req_addr = 24'h000000; req_len = 5'd1; req_fast = 1'b0; req_start = 1'b1;
        cycles(1);
        req_start = 1'b0;
        wait_done("t2", 2000);
        lvl_en = 1'b0;
        chk("t2 mosi hdr", cmd_sr, 32'h0BABCDEF);
        chk("t2 sck count", nrise, 168);
        chk("t2 mosi dummy", late_ones, 0);
        chk("t2 nwords", got_w.size(), 4);
        chk("t2 w0", gw(0), 32'h01234567);
        chk("t2 w1", gw(1), 32'h89ABCDEF);
        chk("t2 w2", gw(2), 32'hCAFEF00D);
        chk("t2 w3", gw(3), 32'h5A5AA5A5);
        chk("t2 last", lasts(), 16'h0008);
        chk("t2 sck level", lvl_bad, 0);
        chk("t2 err", last_err, 0);
        cycles(20);
        chk("t2 one done", n_done - nd, 1);

        // backpressure: word 1 left unaccepted for 20 cycles
        dwords[0] = 32'h11112222; dwords[1] = 32'h33334444; dwords[2] = 32'h55556666;
        rd_ready = 1'b0; max_hi = 0;
        start(24'h000040, 5'd3, 1'b0);
        k = 0;
        while (rd_valid !== 1'b1 && k < 1000) begin cycles(1); k++; end
        chk("t3 w1 valid", rd_valid, 1);
        cycles(20);
        chk("t3 held data", rd_data, 32'h11112222);
        chk("t3 held valid", rd_valid, 1);
        chk("t3 hold sel", spi_sel, 0);
        chk("t3 hold sck", spi_clk, 1);
        rd_ready = 1'b1;
        wait_done("t3", 2000);
        chk("t3 hold len", 64'(max_hi >= 20), 1);
        chk("t3 nwords", got_w.size(), 3);
        chk("t3 w0", gw(0), 32'h11112222);
        chk("t3 w1", gw(1), 32'h33334444);
        chk("t3 w2", gw(2), 32'h55556666);
        chk("t3 last", lasts(), 16'h0004);
        chk("t3 sck count", nrise, 128);

        // rejected lengths: 0 and above MAX_WORDS
        sl = sel_low_cnt;
        start(24'h000010, 5'd0, 1'b0);
        @(negedge clk);
        chk("t4 len0 done", {rd_done, rd_err}, 2'b11);
        chk("t4 len0 busy", busy, 0);
        start(24'h000010, 5'd17, 1'b1);
        @(negedge clk);
        chk("t4 len17 done", {rd_done, rd_err}, 2'b11);
        cycles(10);
        chk("t4 no spi", sel_low_cnt - sl, 0);

        // abort during ADDR, then a request coinciding with abort in IDLE
        start(24'h654321, 5'd2, 1'b0);
        k = 0;
        while (nrise < 10 && k < 500) begin cycles(1); k++; end
        chk("t5 in addr", 64'(nrise >= 10 && nrise < 32), 1);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        @(negedge clk);
        chk("t5 sel up", spi_sel, 1);
        chk("t5 sck high", spi_clk, 1);
        chk("t5 no early done", rd_done, 0);
        k = 0;
        while (rd_done !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        chk("t5 done delay", k, 2);
        chk("t5 err", rd_err, 1);
        dwords[0] = 32'h13579BDF;
        abort = 1'b1;
        start(24'h000100, 5'd1, 1'b0);
        abort = 1'b0;
        wait_done("t5b", 1000);
        chk("t5b word", gw(0), 32'h13579BDF);
        chk("t5b err", last_err, 0);

        // reset during DATA
        start(24'h222222, 5'd2, 1'b0);
        k = 0;
        while (nrise < 40 && k < 500) begin cycles(1); k++; end
        nd = n_done;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6 rst sel/sck", {spi_sel, spi_clk, spi0}, 3'b110);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst outs", {rd_valid, rd_last, rd_done, rd_err}, 0);
        chk("t6 rst data", rd_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycles(10);
        chk("t6 no done", n_done - nd, 0);
        dwords[0] = 32'h0F0F1234;
        start(24'h00FFFF, 5'd1, 1'b0);
        wait_done("t6b", 1000);
        chk("t6b hdr", cmd_sr, 32'h0300FFFF);
        chk("t6b word", gw(0), 32'h0F0F1234);
        chk("t6b last", lasts(), 16'h0001);
        chk("t6b err", last_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
